pwm_breather: RTL and testbench



---
 rtl/pwm_breather_pkg.sv | 15 +
 rtl/pwm_breather_edge_sync.sv | 29 ++
 rtl/pwm_breather.sv | 139 +++++++++++++
 tb/tb_pwm_breather.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_breather_pkg.sv
// Shared types for the LED breathing PWM block.
// The state encoding is visible on the `state` port, so the values are fixed.
package pwm_breather_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

endpackage

// File: rtl/pwm_breather_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for a slow divider output.
// Produces a registered single-cycle pulse in the clk domain.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q, pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            // s3 only delays s2; it is never used to resolve metastability
            pulse_q <= s2_q & ~s3_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pwm_breather.sv
// Breathing LED driver: a triangle ramp of the PWM duty, stepped once per
// synchronized rising edge of slow_in, feeding a free-running PWM carrier.
module pwm_breather
    import pwm_breather_pkg::*;
#(
    parameter int PWM_WIDTH  = 8,
    parameter int DUTY_MAX   = 255,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 slow_in,
    output logic                 pwm_out,
    output logic [PWM_WIDTH-1:0] duty,
    output logic [STATE_W-1:0]   state,
    output logic                 tick,
    output logic                 peak
);

    localparam int HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PWM_WIDTH:0]   DMAX_X    = (PWM_WIDTH+1)'(DUTY_MAX);
    localparam logic [PWM_WIDTH-1:0] DMAX_W    = PWM_WIDTH'(DUTY_MAX);
    localparam logic [PWM_WIDTH:0]   STEP_X    = (PWM_WIDTH+1)'(STEP);
    localparam logic [PWM_WIDTH-1:0] STEP_W    = PWM_WIDTH'(STEP);
    localparam logic [HCW-1:0]       HOLD_LAST = HCW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    state_e               state_q;
    logic [PWM_WIDTH-1:0] duty_q;
    logic [HCW-1:0]       hold_q;
    logic                 peak_q;
    logic [PWM_WIDTH-1:0] pwm_cnt_q;
    logic [PWM_WIDTH-1:0] duty_active_q;
    logic                 pwm_out_q;
    logic                 tick_w;

    logic [PWM_WIDTH:0]   up_sum;
    logic                 up_hit;
    logic                 dn_hit;
    logic [PWM_WIDTH-1:0] up_duty_d;
    logic [PWM_WIDTH-1:0] dn_duty_d;

    edge_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (slow_in),
        .pulse_o (tick_w)
    );

    // Ramp arithmetic is one bit wider than duty so the saturation test never wraps.
    always_comb begin
        up_sum    = {1'b0, duty_q} + STEP_X;
        up_hit    = (up_sum >= DMAX_X);
        up_duty_d = up_hit ? DMAX_W : up_sum[PWM_WIDTH-1:0];
        dn_hit    = ({1'b0, duty_q} <= STEP_X);
        dn_duty_d = dn_hit ? '0 : (duty_q - STEP_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
            peak_q  <= 1'b0;
        end else begin
            peak_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                duty_q  <= '0;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        duty_q  <= '0;
                        state_q <= UP;
                    end
                    UP: if (tick_w) begin
                        duty_q <= up_duty_d;
                        if (up_hit) begin
                            peak_q  <= 1'b1;
                            hold_q  <= '0;
                            state_q <= (HOLD_TICKS == 0) ? DOWN : HOLD_HI;
                        end
                    end
                    HOLD_HI: if (tick_w) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            state_q <= DOWN;
                        end else begin
                            hold_q <= hold_q + HCW'(1);
                        end
                    end
                    DOWN: if (tick_w) begin
                        duty_q <= dn_duty_d;
                        if (dn_hit) begin
                            hold_q  <= '0;
                            state_q <= (HOLD_TICKS == 0) ? UP : HOLD_LO;
                        end
                    end
                    HOLD_LO: if (tick_w) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            state_q <= UP;
                        end else begin
                            hold_q <= hold_q + HCW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        duty_q  <= '0;
                        hold_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Duty is latched only at the carrier wrap so a period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q     <= '0;
            duty_active_q <= '0;
            pwm_out_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
            if (pwm_cnt_q == {PWM_WIDTH{1'b1}})
                duty_active_q <= duty_q;
            pwm_out_q <= en & (pwm_cnt_q < duty_active_q);
        end
    end

    assign pwm_out = pwm_out_q;
    assign duty    = duty_q;
    assign state   = state_q;
    assign tick    = tick_w;
    assign peak    = peak_q;

endmodule

// File: tb/tb_pwm_breather.sv
// Bench for pwm_breather: four parameter sets share one stimulus stream and are
// compared every cycle against a ramp/PWM reference model, plus directed sequences.
module tb_pwm_breather;

    logic clk = 1'b0;
    logic rst, en, slow_in;
    always #5 clk = ~clk;

    logic       pwm_a, pwm_b, pwm_c, pwm_d;
    logic [3:0] duty_a, duty_b, duty_c;
    logic [7:0] duty_d;
    logic [2:0] st_a, st_b, st_c, st_d;
    logic       tk_a, tk_b, tk_c, tk_d;
    logic       pk_a, pk_b, pk_c, pk_d;

    pwm_breather #(.PWM_WIDTH(4), .DUTY_MAX(15), .STEP(5), .HOLD_TICKS(2)) u_a (
        .clk(clk), .rst(rst), .en(en), .slow_in(slow_in),
        .pwm_out(pwm_a), .duty(duty_a), .state(st_a), .tick(tk_a), .peak(pk_a));
    pwm_breather #(.PWM_WIDTH(4), .DUTY_MAX(10), .STEP(4), .HOLD_TICKS(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .slow_in(slow_in),
        .pwm_out(pwm_b), .duty(duty_b), .state(st_b), .tick(tk_b), .peak(pk_b));
    pwm_breather #(.PWM_WIDTH(4), .DUTY_MAX(15), .STEP(5), .HOLD_TICKS(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .slow_in(slow_in),
        .pwm_out(pwm_c), .duty(duty_c), .state(st_c), .tick(tk_c), .peak(pk_c));
    pwm_breather #(.PWM_WIDTH(8), .DUTY_MAX(255), .STEP(8), .HOLD_TICKS(4)) u_d (
        .clk(clk), .rst(rst), .en(en), .slow_in(slow_in),
        .pwm_out(pwm_d), .duty(duty_d), .state(st_d), .tick(tk_d), .peak(pk_d));

    localparam int CW[4] = '{4, 4, 4, 8};
    localparam int DM[4] = '{15, 10, 15, 255};
    localparam int ST[4] = '{5, 4, 5, 8};
    localparam int HT[4] = '{2, 1, 0, 4};

    // Reference model: phase 0..4 = idle/rising/top/falling/bottom.
    typedef struct packed {
        logic [2:0] hist;   // slow_in samples, [0] newest
        logic       tick;
        int         ph;
        int         duty;
        int         hold;   // ticks already spent in the current hold
        logic       peak;
        int         cnt;
        int         da;
        logic       pwm;
    } mdl_t;

    mdl_t m[4];

    function automatic mdl_t mstep(mdl_t c, logic e, logic s, int i);
        mdl_t n;
        int   d;
        n      = c;
        n.tick = c.hist[1] & ~c.hist[2];
        n.hist = {c.hist[1:0], s};
        n.peak = 1'b0;
        if (!e) begin
            n.ph = 0; n.duty = 0; n.hold = 0;
        end else if (c.ph == 0) begin
            n.ph = 1;
        end else if (c.tick) begin
            case (c.ph)
                1: begin
                    d = c.duty + ST[i];
                    if (d > DM[i]) d = DM[i];
                    n.duty = d;
                    if (d == DM[i]) begin
                        n.peak = 1'b1; n.hold = 0;
                        n.ph = (HT[i] == 0) ? 3 : 2;
                    end
                end
                3: begin
                    d = c.duty - ST[i];
                    if (d < 0) d = 0;
                    n.duty = d;
                    if (d == 0) begin
                        n.hold = 0;
                        n.ph = (HT[i] == 0) ? 1 : 4;
                    end
                end
                default: begin
                    if (c.hold + 1 >= HT[i]) begin
                        n.hold = 0;
                        n.ph = (c.ph == 2) ? 3 : 1;
                    end else begin
                        n.hold = c.hold + 1;
                    end
                end
            endcase
        end
        n.pwm = e && (c.cnt < c.da);
        if (c.cnt == (1 << CW[i]) - 1) begin
            n.cnt = 0; n.da = c.duty;
        end else begin
            n.cnt = c.cnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) m[i] <= mstep(m[i], en, slow_in, i);
        end
    end

    // Observation word: {pwm, duty[7:0], state[2:0], tick, peak}
    function automatic logic [13:0] obs(int i);
        case (i)
            0:       return {pwm_a, 4'b0, duty_a, st_a, tk_a, pk_a};
            1:       return {pwm_b, 4'b0, duty_b, st_b, tk_b, pk_b};
            2:       return {pwm_c, 4'b0, duty_c, st_c, tk_c, pk_c};
            default: return {pwm_d, duty_d, st_d, tk_d, pk_d};
        endcase
    endfunction

    function automatic logic [13:0] mpack(mdl_t c);
        return {c.pwm, 8'(c.duty), 3'(c.ph), c.tick, c.peak};
    endfunction

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cycle, got, exp);
        end
    endtask

    // Advance one cycle and compare every DUT against the model.
    task automatic cyc();
        @(negedge clk);
        cycle++;
        for (int i = 0; i < 4; i++)
            chk($sformatf("model dut%0d", i), 16'(obs(i)), 16'(mpack(m[i])));
    endtask

    logic [13:0] cap[4];

    // One slow_in pulse; capture outputs on the cycle the FSM reacts to its tick.
    task automatic do_tick();
        slow_in = 1'b1; cyc(); cyc();
        slow_in = 1'b0; cyc(); cyc();
        for (int i = 0; i < 4; i++) cap[i] = obs(i);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] dsp(logic [13:0] o);
        return {4'b0, o[12:5], o[4:2], o[0]};
    endfunction

    typedef struct {
        int d[3];
        int s[3];
        int p[3];
    } vec_t;

    vec_t tbl[10];

    initial begin
        int found, cnt_a, cnt_b, cnt_c, run, maxrun, tpos, tcnt;
        // duty/state/peak after ticks 1..10 for DUT a, b, c
        tbl[0] = '{'{5, 4, 5},   '{1, 1, 1}, '{0, 0, 0}};
        tbl[1] = '{'{10, 8, 10}, '{1, 1, 1}, '{0, 0, 0}};
        tbl[2] = '{'{15, 10, 15},'{2, 2, 3}, '{1, 1, 1}};
        tbl[3] = '{'{15, 10, 10},'{2, 3, 3}, '{0, 0, 0}};
        tbl[4] = '{'{15, 6, 5},  '{3, 3, 3}, '{0, 0, 0}};
        tbl[5] = '{'{10, 2, 0},  '{3, 3, 1}, '{0, 0, 0}};
        tbl[6] = '{'{5, 0, 5},   '{3, 4, 1}, '{0, 0, 0}};
        tbl[7] = '{'{0, 0, 10},  '{4, 1, 1}, '{0, 0, 0}};
        tbl[8] = '{'{0, 4, 15},  '{4, 1, 3}, '{0, 0, 1}};
        tbl[9] = '{'{0, 8, 10},  '{1, 1, 3}, '{0, 0, 0}};

        rst = 1'b1; en = 1'b0; slow_in = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) chk($sformatf("reset dut%0d", i), 16'(obs(i)), 16'h0);

        // Full triangle
        rst = 1'b0; en = 1'b1;
        cyc(); cyc();
        for (int k = 0; k < 10; k++) begin
            do_tick();
            for (int i = 0; i < 3; i++)
                chk($sformatf("tri t%0d dut%0d", k + 1, i), dsp(cap[i]),
                    {4'b0, 8'(tbl[k].d[i]), 3'(tbl[k].s[i]), 1'(tbl[k].p[i])});
        end

        // Reset mid-ramp at duty 40, then release with slow_in high
        do_reset(); en = 1'b1; cyc();
        for (int k = 0; k < 5; k++) do_tick();
        chk("pre-reset duty d", 16'(duty_d), 16'd40);
        chk("pre-reset state d", 16'(st_d), 16'd1);
        slow_in = 1'b1; rst = 1'b1;
        #1;
        chk("async reset d", 16'(obs(3)), 16'h0);
        chk("async reset a", 16'(obs(0)), 16'h0);
        cyc(); rst = 1'b0;
        tcnt = 0; tpos = 0;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (tk_d) begin tcnt++; tpos = j; end
        end
        chk("rel tick count", 16'(tcnt), 16'd1);
        chk("rel tick pos", 16'(tpos), 16'd3);
        slow_in = 1'b0; cyc();

        // Enable abort coinciding with a tick at duty 10
        do_reset(); en = 1'b1; cyc();
        do_tick(); do_tick();
        chk("abort pre duty", 16'(duty_a), 16'd10);
        slow_in = 1'b1; found = 0;
        for (int j = 0; j < 8 && found == 0; j++) begin
            cyc();
            if (tk_a) found = 1;
        end
        chk("abort tick seen", 16'(found), 16'd1);
        en = 1'b0; slow_in = 1'b0;
        cyc();
        chk("abort state", 16'(st_a), 16'd0);
        chk("abort duty", 16'(duty_a), 16'd0);
        chk("abort pwm", 16'(pwm_a), 16'd0);
        en = 1'b1; cyc();
        chk("reen state", 16'(st_a), 16'd1);
        do_tick();
        chk("reen duty", dsp(cap[0]), {4'b0, 8'd5, 3'd1, 1'b0});

        // PWM accuracy: duty 0 stays low, then steady duty
        do_reset(); en = 1'b1;
        cnt_a = 0;
        for (int j = 0; j < 32; j++) begin cyc(); cnt_a += int'(pwm_a); end
        chk("pwm zero", 16'(cnt_a), 16'd0);
        do_tick();
        repeat (40) cyc();
        cnt_a = 0; cnt_b = 0; cnt_c = 0; run = 0; maxrun = 0;
        for (int j = 0; j < 64; j++) begin
            cyc();
            cnt_a += int'(pwm_a); cnt_b += int'(pwm_b); cnt_c += int'(pwm_c);
            run = pwm_a ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("pwm a high", 16'(cnt_a), 16'd20);
        chk("pwm b high", 16'(cnt_b), 16'd16);
        chk("pwm c high", 16'(cnt_c), 16'd20);
        chk("pwm a run", 16'(maxrun), 16'd5);

        // Randomized traffic against the model
        do_reset(); en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            en  = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 3) == 0) slow_in = ~slow_in;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
